m6809_romsel_ctrl: RTL

M6809_ROMSEL_CTRL -- requirements
Module: m6809_romsel_ctrl

---
 rtl/m6809_romsel_ctrl.sv | 78 +++++++
 1 files changed

// File: rtl/m6809_romsel_ctrl.sv
// m6809_romsel_ctrl: 6809 ROM socket/slot selector with keyed software slot select and ROM wait states
// Ports: clk, reset (sync, active-high); dip[2:0] boot slot, dip[4:3] wait states, dip[7] select disable;
//        e, vma, adr15, adr14, rnw, regsel_b, data from the CPU bus;
//        rom01cs_b/rom23cs_b/rom45cs_b, roma14, romoe_b drive the ROM sockets;
//        mrdy stretches ROM cycles; slot, locked report state; romdis tied low.
module m6809_romsel_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dip,
  input  logic       e,
  input  logic       vma,
  input  logic       adr15,
  input  logic       adr14,
  input  logic       rnw,
  input  logic       regsel_b,
  input  logic [7:0] data,
  output logic       rom01cs_b,
  output logic       rom23cs_b,
  output logic       rom45cs_b,
  output logic       roma14,
  output logic       romoe_b,
  output logic       mrdy,
  output logic [2:0] slot,
  output logic       locked,
  output logic       romdis
);
  typedef enum logic [1:0] {LOCKED, KEY1, OPEN} key_t;
  key_t state, state_nx;
  logic rom_acc, e_prev, e_rise, wr_cond, wr_seen, wr_ev, slot_ok, take, pend;
  logic [2:0] pend_slot;
  logic [1:0] cnt;
  logic unused;
  assign unused = ^dip[6:5];
  assign rom_acc = vma & adr15 & adr14;
  assign e_rise = e & ~e_prev;
  assign wr_cond = vma & ~regsel_b & ~rnw & e;
  // wr_seen remembers a write already taken in this E-high phase so a held strobe fires once
  assign wr_ev = wr_cond & ~wr_seen & ~dip[7];
  assign slot_ok = (data[7:3] == 5'd0) && (data[2:0] <= 3'd5);
  assign take = wr_ev & (state == OPEN) & slot_ok;
  always_comb begin
    state_nx = state;
    if (dip[7]) state_nx = LOCKED;
    else if (wr_ev) state_nx = (state == LOCKED && data == 8'hA5) ? KEY1 : (state == KEY1 && data == 8'h5A) ? OPEN : LOCKED;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOCKED;
      slot <= (dip[2:0] <= 3'd5) ? dip[2:0] : 3'd0;
      pend <= 1'b0;
      pend_slot <= 3'd0;
      cnt <= 2'd0;
      e_prev <= 1'b0;
      wr_seen <= 1'b0;
    end else begin
      state <= state_nx;
      e_prev <= e;
      wr_seen <= e & (wr_seen | wr_cond);
      // a fresh select write wins over the transfer; the new value moves on the next idle clk
      if (take) begin
        pend_slot <= data[2:0];
        pend <= 1'b1;
      end else if (pend & ~rom_acc) begin
        slot <= pend_slot;
        pend <= 1'b0;
      end
      cnt <= (e_rise & rom_acc) ? dip[4:3] : (cnt != 2'd0) ? cnt - 2'd1 : cnt;
    end
  end
  assign rom01cs_b = ~(rom_acc & (slot[2:1] == 2'd0));
  assign rom23cs_b = ~(rom_acc & (slot[2:1] == 2'd1));
  assign rom45cs_b = ~(rom_acc & (slot[2:1] == 2'd2));
  assign roma14 = slot[0];
  assign romoe_b = ~(rom_acc & rnw);
  assign mrdy = (cnt == 2'd0);
  assign locked = (state != OPEN);
  assign romdis = 1'b0;
endmodule
